// File: rtl/spin_pkg.sv
// -----------------------------------------------------------------------------
// spin_pkg
// Shared definitions for the LED spinner speed controller: code widths, level
// limits, the controller state encoding and the level -> thermometer mapping.
// -----------------------------------------------------------------------------
package spin_pkg;

  localparam int SPEED_W = 4;
  localparam int LVL_W   = 3;

  localparam logic [LVL_W-1:0] LVL_MIN = 3'd0;
  localparam logic [LVL_W-1:0] LVL_MAX = 3'd4;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } spin_state_e;

  // Level 0..4 -> 0000/0001/0011/0111/1111. Levels above 4 are never
  // produced; they map to full speed so the prescaler never sees a gap.
  function automatic logic [SPEED_W-1:0] lvl2therm(input logic [LVL_W-1:0] lvl);
    logic [SPEED_W-1:0] code;
    case (lvl)
      3'd0:    code = 4'b0000;
      3'd1:    code = 4'b0001;
      3'd2:    code = 4'b0011;
      3'd3:    code = 4'b0111;
      default: code = 4'b1111;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronizes one asynchronous button, debounces it and emits a one-cycle
// pulse when the debounced state rises.
// Ports:
//   clk_i    in  system clock
//   rst_ni   in  asynchronous active-low reset
//   btn_i    in  raw asynchronous button, active-high
//   press_o  out one-cycle pulse on an accepted 0->1 transition
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SS-1:0]    r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_state;
  logic             r_press;
  logic             w_sync;

  assign w_sync  = r_sync[SS-1];
  assign press_o = r_press;

  // The counter only advances while the input disagrees with the accepted
  // state; any return to agreement restarts the stability window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SS-2:0], btn_i};
      r_press <= 1'b0;
      if (w_sync != r_state) begin
        if (r_cnt == CNT_LAST) begin
          r_state <= w_sync;
          r_cnt   <= '0;
          r_press <= w_sync;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/spin_speed_ctrl.sv
// -----------------------------------------------------------------------------
// spin_speed_ctrl
// Turns debounced up/down buttons or an automatic triangle ramp into the
// thermometer speed code for the spinner prescaler. The applied level only
// changes in the cycle after a prescaler tick, when its counter is 0.
// Ports:
//   clk_i       in  system clock
//   rst_ni      in  asynchronous active-low reset
//   btn_up_i    in  raw up button (async)
//   btn_down_i  in  raw down button (async)
//   auto_i      in  auto-ramp switch (async), 1 = ramp
//   tick_i      in  prescaler tick, one-cycle pulse
//   speed_o     out thermometer speed code
//   level_o     out applied level 0..4
//   pending_o   out target level differs from applied level
//   at_max_o    out applied level == 4
//   at_min_o    out applied level == 0
// -----------------------------------------------------------------------------
module spin_speed_ctrl
  import spin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RAMP_TICKS      = 8,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               btn_up_i,
  input  logic               btn_down_i,
  input  logic               auto_i,
  input  logic               tick_i,
  output logic [SPEED_W-1:0] speed_o,
  output logic [LVL_W-1:0]   level_o,
  output logic               pending_o,
  output logic               at_max_o,
  output logic               at_min_o
);

  localparam int SS     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int RAMP_W = (RAMP_TICKS > 2) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_TICKS - 1);
  localparam logic [LVL_W-1:0]  LVL_MAX_M1 = LVL_MAX - 3'd1;
  localparam logic [LVL_W-1:0]  LVL_MIN_P1 = LVL_MIN + 3'd1;

  logic              w_up_press;
  logic              w_dn_press;
  logic [SS-1:0]     r_auto_sync;
  logic              w_auto;

  spin_state_e       r_state, w_state_next;
  logic [LVL_W-1:0]  r_target, w_target_next;
  logic [LVL_W-1:0]  r_applied;
  logic [RAMP_W-1:0] r_ramp, w_ramp_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SS)) u_db_up (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (btn_up_i),
    .press_o (w_up_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SS)) u_db_dn (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (btn_down_i),
    .press_o (w_dn_press)
  );

  assign w_auto = r_auto_sync[SS-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_auto_sync <= '0;
      r_state     <= MANUAL;
      r_target    <= LVL_MIN;
      r_applied   <= LVL_MIN;
      r_ramp      <= '0;
    end else begin
      r_auto_sync <= {r_auto_sync[SS-2:0], auto_i};
      r_state     <= w_state_next;
      r_target    <= w_target_next;
      r_ramp      <= w_ramp_next;
      // Reads the pre-edge target: a target change made in a tick cycle
      // waits for the following tick.
      if (tick_i && (r_target != r_applied)) begin
        r_applied <= r_target;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_target_next = r_target;
    w_ramp_next   = r_ramp;
    case (r_state)
      MANUAL: begin
        if (w_auto) begin
          w_state_next = RAMP_UP;
          w_ramp_next  = '0;
        end else if (w_up_press && !w_dn_press) begin
          if (r_target != LVL_MAX) w_target_next = r_target + 1'b1;
        end else if (w_dn_press && !w_up_press) begin
          if (r_target != LVL_MIN) w_target_next = r_target - 1'b1;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (!w_auto) begin
          w_state_next = MANUAL;
          w_ramp_next  = '0;
        end else if (tick_i) begin
          if (r_ramp == RAMP_LAST) begin
            w_ramp_next = '0;
            if (r_state == RAMP_UP) begin
              // Entering the ramp at the top turns straight around.
              if (r_target == LVL_MAX) begin
                w_target_next = r_target - 1'b1;
                w_state_next  = RAMP_DOWN;
              end else begin
                w_target_next = r_target + 1'b1;
                if (r_target == LVL_MAX_M1) w_state_next = RAMP_DOWN;
              end
            end else begin
              if (r_target == LVL_MIN) begin
                w_target_next = r_target + 1'b1;
                w_state_next  = RAMP_UP;
              end else begin
                w_target_next = r_target - 1'b1;
                if (r_target == LVL_MIN_P1) w_state_next = RAMP_UP;
              end
            end
          end else begin
            w_ramp_next = r_ramp + 1'b1;
          end
        end
      end
      default: w_state_next = MANUAL;
    endcase
  end

  assign speed_o   = lvl2therm(r_applied);
  assign level_o   = r_applied;
  assign pending_o = (r_target != r_applied);
  assign at_max_o  = (r_applied == LVL_MAX);
  assign at_min_o  = (r_applied == LVL_MIN);

endmodule

// File: tb/tb_spin_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spin_speed_ctrl
// Directed self-checking bench for spin_speed_ctrl with DEBOUNCE_CYCLES=4,
// RAMP_TICKS=2. Expected output states are queued as stimulus is applied and
// compared against the DUT when the corresponding result is due.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spin_speed_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       btn_up_i;
  logic       btn_down_i;
  logic       auto_i;
  logic       tick_i;
  logic [3:0] speed_o;
  logic [2:0] level_o;
  logic       pending_o;
  logic       at_max_o;
  logic       at_min_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] spd;
    logic [2:0] lvl;
    logic       pend;
    logic       mx;
    logic       mn;
  } exp_t;

  exp_t exp_q[$];

  spin_speed_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .RAMP_TICKS      (2),
    .SYNC_STAGES     (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .btn_up_i   (btn_up_i),
    .btn_down_i (btn_down_i),
    .auto_i     (auto_i),
    .tick_i     (tick_i),
    .speed_o    (speed_o),
    .level_o    (level_o),
    .pending_o  (pending_o),
    .at_max_o   (at_max_o),
    .at_min_o   (at_min_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] therm(input int lvl);
    logic [3:0] t;
    t = 4'b0000;
    for (int i = 0; i < lvl; i++) t[i] = 1'b1;
    return t;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_tick();
    tick_i = 1'b1;
    cyc(1);
    tick_i = 1'b0;
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up_i   = up;
    btn_down_i = dn;
    cyc(8);
    btn_up_i   = 1'b0;
    btn_down_i = 1'b0;
    cyc(8);
  endtask

  task automatic push_exp(input string tag, input int lvl, input logic pend);
    exp_t e;
    e.tag  = tag;
    e.lvl  = 3'(lvl);
    e.spd  = therm(lvl);
    e.pend = pend;
    e.mx   = (lvl == 4);
    e.mn   = (lvl == 0);
    exp_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: queue size %0d, required > 0", exp_q.size());
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert ({speed_o, level_o, pending_o, at_max_o, at_min_o} ===
              {e.spd, e.lvl, e.pend, e.mx, e.mn}) begin
        $display("[%0t] %s: speed=%b level=%0d pend=%b max=%b min=%b ok",
                 $time, e.tag, speed_o, level_o, pending_o, at_max_o, at_min_o);
      end else begin
        errors++;
        $error("FAIL %s: got speed=%b level=%0d pend=%b max=%b min=%b, expected speed=%b level=%0d pend=%b max=%b min=%b",
               e.tag, speed_o, level_o, pending_o, at_max_o, at_min_o,
               e.spd, e.lvl, e.pend, e.mx, e.mn);
      end
    end
  endtask

  // Applied level and pending flag after each ramp tick, entering at level 3.
  int ramp_app [1:14] = '{3, 3, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0, 1, 1};
  logic ramp_pnd [1:14] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; btn_up_i = 1'b0; btn_down_i = 1'b0; auto_i = 1'b0; tick_i = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      btn_up_i   = 1'($urandom_range(0, 1));
      btn_down_i = 1'($urandom_range(0, 1));
      auto_i     = 1'($urandom_range(0, 1));
      tick_i     = 1'($urandom_range(0, 1));
      cyc(1);
    end
    btn_up_i = 1'b0; btn_down_i = 1'b0; auto_i = 1'b0; tick_i = 1'b0;
    push_exp("in_reset", 0, 1'b0); check_pop();
    rst_ni = 1'b1;
    cyc(10);
    push_exp("after_reset", 0, 1'b0); check_pop();

    // Bouncing up button: only the final stable hold is accepted
    for (int i = 0; i < 10; i++) begin
      btn_up_i = ~btn_up_i;
      cyc(2);
    end
    btn_up_i = 1'b1; cyc(8); btn_up_i = 1'b0; cyc(8);
    push_exp("bounce_pending", 0, 1'b1); check_pop();
    tick_i = 1'b1;
    push_exp("bounce_tick_cycle", 0, 1'b1); check_pop();
    cyc(1); tick_i = 1'b0;
    push_exp("bounce_commit", 1, 1'b0); check_pop();

    // Saturation and simultaneous presses
    repeat (6) press(1'b1, 1'b0);
    push_exp("sat_pending", 1, 1'b1); check_pop();
    do_tick();
    push_exp("sat_max", 4, 1'b0); check_pop();
    press(1'b1, 1'b1);
    push_exp("simultaneous", 4, 1'b0); check_pop();
    repeat (4) press(1'b0, 1'b1);
    do_tick();
    push_exp("down_to_min", 0, 1'b0); check_pop();
    press(1'b0, 1'b1);
    push_exp("down_at_min", 0, 1'b0); check_pop();

    // Press lands 3 cycles before a tick
    btn_up_i = 1'b1;
    cyc(7);
    push_exp("early_press_pending", 0, 1'b1); check_pop();
    cyc(2);
    tick_i = 1'b1;
    push_exp("early_tick_cycle", 0, 1'b1); check_pop();
    cyc(1); tick_i = 1'b0;
    push_exp("early_commit", 1, 1'b0); check_pop();
    btn_up_i = 1'b0; cyc(8);

    // Press lands in the same cycle as a tick
    btn_up_i = 1'b1;
    cyc(6);
    tick_i = 1'b1;
    cyc(1); tick_i = 1'b0;
    push_exp("same_cycle_no_commit", 1, 1'b1); check_pop();
    btn_up_i = 1'b0; cyc(8);
    do_tick();
    push_exp("same_cycle_next_tick", 2, 1'b0); check_pop();

    press(1'b1, 1'b0);
    do_tick();
    push_exp("level3", 3, 1'b0); check_pop();

    // Auto ramp, tick every 10 cycles, buttons pressed along the way
    auto_i = 1'b1;
    cyc(4);
    for (int k = 1; k <= 14; k++) begin
      tick_i = 1'b1;
      push_exp($sformatf("ramp_tick%0d", k), ramp_app[k], ramp_pnd[k]);
      cyc(1); tick_i = 1'b0;
      check_pop();
      if (k == 3) btn_up_i = 1'b1;
      if (k == 5) btn_up_i = 1'b0;
      if (k == 7) btn_down_i = 1'b1;
      if (k == 9) btn_down_i = 1'b0;
      if (k != 14) cyc(9);
    end

    // Leave auto mode with a commit in flight
    auto_i = 1'b0;
    cyc(4);
    push_exp("exit_pending", 1, 1'b1); check_pop();
    cyc(5);
    do_tick();
    push_exp("exit_commit", 2, 1'b0); check_pop();
    cyc(9);
    do_tick();
    push_exp("exit_frozen", 2, 1'b0); check_pop();

    // Asynchronous reset mid-ramp
    auto_i = 1'b1;
    cyc(4);
    do_tick(); cyc(9);
    do_tick(); cyc(5);
    push_exp("ramp_before_reset", 2, 1'b1); check_pop();
    rst_ni = 1'b0;
    #1;
    push_exp("async_reset", 0, 1'b0); check_pop();
    auto_i = 1'b0;
    cyc(2);
    rst_ni = 1'b1;
    cyc(3);
    push_exp("post_async_reset", 0, 1'b0); check_pop();

    // No tick ever arrives: change stays pending
    press(1'b1, 1'b0);
    cyc(40);
    push_exp("no_tick_pending", 0, 1'b1); check_pop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
